// File: rtl/gemm_mem_sequencer_if.sv
//============================================================================
// Module   : gemm_mem_sequencer_if
// Purpose  : Command, scratchpad-port and stream bundle of the GEMM sequencer
// Revision : 1.0
//============================================================================
`default_nettype none

interface gemm_mem_sequencer_if #(
    parameter int NUM_RAMS = 16,
    parameter int D_WID    = 8,
    parameter int CNT_WID  = 8
);
    logic               start;
    logic               dir;
    logic [31:0]        base_addr;
    logic [31:0]        stride;
    logic [CNT_WID-1:0] num_rows;
    logic [4:0]         row_len;
    logic               busy;
    logic               done;
    logic               err;

    logic               mem_en;
    logic               mem_rdwr;
    logic [4:0]         mem_control;
    logic [31:0]        mem_addr;
    logic [D_WID-1:0]   mem_wr_data [NUM_RAMS];
    logic [D_WID-1:0]   mem_rd_data [NUM_RAMS];

    logic               rd_valid;
    logic               rd_last;
    logic               rd_ready;
    logic [D_WID-1:0]   rd_data [NUM_RAMS];

    logic               wr_valid;
    logic               wr_ready;
    logic [D_WID-1:0]   wr_data [NUM_RAMS];

    modport master (
        output start, dir, base_addr, stride, num_rows, row_len,
        input  busy, done, err,
        input  mem_en, mem_rdwr, mem_control, mem_addr, mem_wr_data,
        output mem_rd_data,
        input  rd_valid, rd_last, rd_data,
        output rd_ready,
        output wr_valid, wr_data,
        input  wr_ready
    );

    modport slave (
        input  start, dir, base_addr, stride, num_rows, row_len,
        output busy, done, err,
        output mem_en, mem_rdwr, mem_control, mem_addr, mem_wr_data,
        input  mem_rd_data,
        output rd_valid, rd_last, rd_data,
        input  rd_ready,
        input  wr_valid, wr_data,
        output wr_ready
    );
endinterface

`default_nettype wire

// File: rtl/gemm_mem_sequencer.sv
//============================================================================
// Module   : gemm_mem_sequencer
// Purpose  : Strided row mover between the GEMM scratchpad port and streams
// Revision : 1.0
//============================================================================
`default_nettype none

module gemm_mem_sequencer #(
    parameter int NUM_RAMS = 16,
    parameter int D_WID    = 8,
    parameter int CNT_WID  = 8
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    gemm_mem_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [31:0]        r_addr;
    logic [31:0]        r_stride;
    logic [CNT_WID-1:0] r_num_rows;
    logic [CNT_WID-1:0] r_issued;
    logic [4:0]         r_row_len;
    logic               r_inflight;
    logic               r_inflight_last;
    logic               r_err;
    logic               r_wr_done;

    logic [D_WID-1:0]   r_fifo [2][NUM_RAMS];
    logic [1:0]         r_fifo_last;
    logic               r_head;
    logic [1:0]         r_count;

    logic               w_cfg_ok;
    logic               w_accept;
    logic               w_reject;
    logic               w_rows_left;
    logic               w_last_row;
    logic               w_pop;
    logic               w_push;
    logic               w_tail;
    logic               w_rd_issue;
    logic               w_wr_issue;
    logic               w_issue;
    logic               w_rd_valid;

    assign w_cfg_ok    = (bus.num_rows != '0) && (bus.row_len != 5'd0) &&
                         (bus.row_len <= 5'(NUM_RAMS));
    assign w_accept    = (r_state == IDLE) && bus.start && w_cfg_ok;
    assign w_reject    = (r_state == IDLE) && bus.start && !w_cfg_ok;
    assign w_rows_left = (r_issued != r_num_rows);
    assign w_last_row  = (r_issued == r_num_rows - CNT_WID'(1));
    assign w_rd_valid  = (r_count != 2'd0);
    assign w_pop       = w_rd_valid && bus.rd_ready;
    assign w_push      = r_inflight;
    assign w_tail      = r_head ^ r_count[0];

    // Occupancy after this cycle's pop must leave room for every read in flight.
    assign w_rd_issue  = (r_state == READ) && w_rows_left &&
                         (({1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop}) < 3'd2);
    assign w_wr_issue  = (r_state == WRITE) && w_rows_left && bus.wr_valid;
    assign w_issue     = w_rd_issue || w_wr_issue;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_next = bus.dir ? WRITE : READ;
            READ:    if (w_pop && r_fifo_last[r_head]) w_state_next = IDLE;
            WRITE:   if (w_wr_issue && w_last_row) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.busy        = (r_state != IDLE);
        bus.done        = ((r_state == READ) && w_pop && r_fifo_last[r_head]) || r_wr_done;
        bus.err         = r_err;
        bus.wr_ready    = (r_state == WRITE) && w_rows_left;
        bus.rd_valid    = w_rd_valid;
        bus.rd_last     = w_rd_valid && r_fifo_last[r_head];
        bus.mem_en      = w_issue;
        bus.mem_rdwr    = w_wr_issue;
        bus.mem_control = w_issue ? r_row_len : 5'd0;
        bus.mem_addr    = w_issue ? r_addr : 32'd0;
        for (int i = 0; i < NUM_RAMS; i++) begin
            bus.mem_wr_data[i] = w_wr_issue ? bus.wr_data[i] : '0;
            bus.rd_data[i]     = r_fifo[r_head][i];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state         <= IDLE;
            r_addr          <= 32'd0;
            r_stride        <= 32'd0;
            r_num_rows      <= '0;
            r_issued        <= '0;
            r_row_len       <= 5'd0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_err           <= 1'b0;
            r_wr_done       <= 1'b0;
            r_fifo_last     <= 2'b00;
            r_head          <= 1'b0;
            r_count         <= 2'd0;
        end else begin
            r_state         <= w_state_next;
            r_err           <= w_reject;
            r_wr_done       <= w_wr_issue && w_last_row;
            r_inflight      <= w_rd_issue;
            r_inflight_last <= w_rd_issue && w_last_row;

            if (w_accept) begin
                r_addr     <= bus.base_addr;
                r_stride   <= bus.stride;
                r_num_rows <= bus.num_rows;
                r_row_len  <= bus.row_len;
                r_issued   <= '0;
            end else if (w_issue) begin
                r_addr   <= r_addr + r_stride;
                r_issued <= r_issued + CNT_WID'(1);
            end

            if (w_push) r_fifo_last[w_tail] <= r_inflight_last;
            if (w_pop)  r_head <= ~r_head;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload storage carries no reset; occupancy alone decides validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            for (int i = 0; i < NUM_RAMS; i++) begin
                r_fifo[w_tail][i] <= bus.mem_rd_data[i];
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_gemm_mem_sequencer.sv
//============================================================================
// Module   : tb_gemm_mem_sequencer
// Purpose  : Table, directed and random checks of gemm_mem_sequencer
// Revision : 1.0
//============================================================================
`default_nettype none

module tb_gemm_mem_sequencer;
    localparam int NUM_RAMS = 16;
    localparam int D_WID    = 8;
    localparam int CNT_WID  = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    gemm_mem_sequencer_if #(.NUM_RAMS(NUM_RAMS), .D_WID(D_WID), .CNT_WID(CNT_WID)) bus ();
    gemm_mem_sequencer #(.NUM_RAMS(NUM_RAMS), .D_WID(D_WID), .CNT_WID(CNT_WID)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        bit          d;
        logic [31:0] b;
        logic [31:0] s;
        int          rows;
        int          len;
        logic [31:0] exp_last;
        int          exp_done;
    } vec_t;

    int          n_checks = 0;
    int          n_pass   = 0;
    bit          pend     = 1'b0;
    logic [31:0] pend_addr;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [7:0] pat(input logic [31:0] a, input int lane);
        return 8'(a[7:0] * 3 + a[15:8] + lane * 29 + a[31:24]);
    endfunction

    // Scratchpad model: read data appears exactly one cycle after the issue.
    task automatic drive_edge();
        @(negedge clk);
        for (int i = 0; i < NUM_RAMS; i++)
            bus.mem_rd_data[i] = pend ? pat(pend_addr, i) : 8'($urandom);
    endtask

    task automatic settle();
        #1;
        pend      = bus.mem_en && !bus.mem_rdwr;
        pend_addr = bus.mem_addr;
    endtask

    task automatic idle_inputs();
        bus.start = 0; bus.dir = 0; bus.base_addr = 0; bus.stride = 0;
        bus.num_rows = 0; bus.row_len = 0; bus.rd_ready = 0; bus.wr_valid = 0;
        for (int i = 0; i < NUM_RAMS; i++) bus.wr_data[i] = 0;
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, ".busy"}, bus.busy, 0);
        chk({tag, ".done"}, bus.done, 0);
        chk({tag, ".err"}, bus.err, 0);
        chk({tag, ".rd_valid"}, {bus.rd_valid, bus.rd_last}, 0);
        chk({tag, ".wr_ready"}, bus.wr_ready, 0);
        chk({tag, ".mem"}, {bus.mem_en, bus.mem_rdwr, bus.mem_control, bus.mem_addr}, 0);
    endtask

    task automatic run_xfer(input bit d, input logic [31:0] b, input logic [31:0] s,
                            input int rows, input int len, input int rdy_pct, input int rdy_hold,
                            input int vld_pct, input bit inject,
                            output int done_cyc, output logic [31:0] last_addr);
        int          n_iss;
        int          n_pop;
        int          cyc;
        bit          fin;
        bit          vld;
        bit          mism;
        logic [31:0] ea;
        logic [D_WID-1:0] wd [NUM_RAMS];
        n_iss = 0; n_pop = 0; cyc = 0; fin = 0;
        done_cyc = -1; last_addr = 32'hDEAD_BEEF;
        drive_edge();
        bus.start = 1; bus.dir = d; bus.base_addr = b; bus.stride = s;
        bus.num_rows = CNT_WID'(rows); bus.row_len = 5'(len);
        bus.rd_ready = 0; bus.wr_valid = 0;
        settle();
        chk("start.idle", {bus.busy, bus.mem_en}, 0);
        while (!fin && cyc < 600) begin
            cyc++;
            drive_edge();
            bus.start     = inject && ($urandom_range(3) == 0);
            bus.dir       = 1'($urandom);
            bus.base_addr = $urandom;
            bus.stride    = $urandom;
            bus.num_rows  = CNT_WID'($urandom);
            bus.row_len   = 5'($urandom);
            bus.rd_ready  = (cyc > rdy_hold) && ($urandom_range(99) < rdy_pct);
            vld           = ($urandom_range(99) < vld_pct);
            bus.wr_valid  = vld;
            for (int i = 0; i < NUM_RAMS; i++) begin
                wd[i] = 8'($urandom);
                bus.wr_data[i] = wd[i];
            end
            settle();
            chk("busy", bus.busy, 1);
            chk("err", bus.err, 0);
            chk("wr_ready", bus.wr_ready, d);
            if (d) chk("wr.mem_en", bus.mem_en, vld);
            if (bus.mem_en) begin
                ea = b + 32'(n_iss) * s;
                last_addr = ea;
                chk("mem_addr", bus.mem_addr, ea);
                chk("mem_control", bus.mem_control, len);
                chk("mem_rdwr", bus.mem_rdwr, d);
                chk("row_count", n_iss < rows, 1);
                if (d) begin
                    mism = 0;
                    for (int i = 0; i < NUM_RAMS; i++) if (bus.mem_wr_data[i] !== wd[i]) mism = 1;
                    chk("mem_wr_data", mism, 0);
                end
                n_iss++;
                if (d && n_iss == rows) fin = 1;
            end else begin
                mism = 0;
                for (int i = 0; i < NUM_RAMS; i++) if (bus.mem_wr_data[i] !== 0) mism = 1;
                chk("noissue.mem", {mism, bus.mem_rdwr, bus.mem_control, bus.mem_addr}, 0);
            end
            if (!d) begin
                if (bus.rd_valid && bus.rd_ready) begin
                    ea = b + 32'(n_pop) * s;
                    mism = 0;
                    for (int i = 0; i < NUM_RAMS; i++) if (bus.rd_data[i] !== pat(ea, i)) mism = 1;
                    chk("rd_data", mism, 0);
                    chk("rd_last", bus.rd_last, n_pop == rows - 1);
                    chk("rd.done", bus.done, n_pop == rows - 1);
                    n_pop++;
                    if (n_pop == rows) begin fin = 1; done_cyc = cyc; end
                end else begin
                    chk("rd.nodone", bus.done, 0);
                end
                chk("outstanding", (n_iss - n_pop) <= 2, 1);
            end else begin
                chk("wr.nodone", bus.done, 0);
            end
        end
        if (!fin) chk("timeout", 0, 1);
        if (d && fin) begin
            drive_edge();
            bus.start = 0; bus.wr_valid = 1;
            settle();
            chk("wr.done_pulse", bus.done, 1);
            chk("wr.after", {bus.busy, bus.wr_ready, bus.mem_en}, 0);
            done_cyc = cyc + 1;
        end
        drive_edge();
        bus.start = 0; bus.rd_ready = 0; bus.wr_valid = 0;
        settle();
        check_quiet("post");
    endtask

    vec_t tbl [6];
    int   ill_rows [4];
    int   ill_len  [4];

    initial begin
        int          dc;
        logic [31:0] la;
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          dc;
        logic [31:0] la;
        tbl[0] = '{1'b0, 32'h10,        32'h10, 3, 16, 32'h30,     5};
        tbl[1] = '{1'b1, 32'h23,        32'h40, 2, 5,  32'h63,     3};
        tbl[2] = '{1'b0, 32'hFFFF_FFF0, 32'h10, 2, 8,  32'h0,      4};
        tbl[3] = '{1'b1, 32'hFFFF_FFF0, 32'h10, 3, 1,  32'h10,     4};
        tbl[4] = '{1'b0, 32'h100,       32'h0,  1, 1,  32'h100,    3};
        tbl[5] = '{1'b1, 32'h8000,      32'h4,  1, 16, 32'h8000,   2};
        ill_rows = '{3, 3, 0, 2};
        ill_len  = '{17, 0, 4, 31};

        rst_n = 0;
        idle_inputs();
        repeat (3) drive_edge();
        #1;
        check_quiet("reset");
        rst_n = 1;
        drive_edge();
        settle();
        check_quiet("after_reset");

        for (int i = 0; i < 6; i++) begin
            run_xfer(tbl[i].d, tbl[i].b, tbl[i].s, tbl[i].rows, tbl[i].len,
                     100, 0, 100, 1'b0, dc, la);
            chk($sformatf("tbl%0d.done_cycle", i), dc, tbl[i].exp_done);
            chk($sformatf("tbl%0d.last_addr", i), la, tbl[i].exp_last);
        end

        for (int i = 0; i < 4; i++) begin
            drive_edge();
            bus.start = 1; bus.dir = 1'(i); bus.base_addr = 32'h40; bus.stride = 32'h10;
            bus.num_rows = CNT_WID'(ill_rows[i]); bus.row_len = 5'(ill_len[i]);
            bus.wr_valid = 1;
            settle();
            chk("ill.start_cycle", {bus.mem_en, bus.busy, bus.err}, 0);
            drive_edge();
            bus.start = 0;
            settle();
            chk($sformatf("ill%0d.err", i), bus.err, 1);
            chk("ill.quiet", {bus.busy, bus.done, bus.mem_en, bus.wr_ready}, 0);
            drive_edge();
            bus.wr_valid = 0;
            settle();
            check_quiet("ill.after");
        end

        run_xfer(1'b0, 32'h1000, 32'h40, 4, 16, 100, 6, 100, 1'b0, dc, la);
        chk("bp.done_cycle", dc, 10);

        drive_edge();
        bus.start = 1; bus.dir = 0; bus.base_addr = 32'h200; bus.stride = 32'h20;
        bus.num_rows = 4; bus.row_len = 16; bus.rd_ready = 0;
        settle();
        drive_edge(); bus.start = 0; settle();
        chk("rst.issue0", {bus.mem_en, bus.mem_addr}, {1'b1, 32'h200});
        drive_edge(); settle();
        chk("rst.issue1", {bus.mem_en, bus.mem_addr}, {1'b1, 32'h220});
        drive_edge(); settle();
        chk("rst.buffered", {bus.rd_valid, bus.mem_en}, 2'b10);
        rst_n = 0;
        drive_edge();
        rst_n = 1; bus.rd_ready = 1;
        settle();
        chk("rst.abort", {bus.rd_valid, bus.busy, bus.done, bus.mem_en}, 0);
        drive_edge(); settle();
        chk("rst.late_data", {bus.rd_valid, bus.done, bus.busy}, 0);
        bus.rd_ready = 0;

        for (int t = 0; t < 25; t++) begin
            bit          d;
            logic [31:0] s;
            d = 1'($urandom);
            s = ($urandom_range(1) == 0) ? 32'($urandom_range(64)) : $urandom;
            run_xfer(d, $urandom, s, $urandom_range(1, 6), $urandom_range(1, 16),
                     $urandom_range(30, 100), 0, $urandom_range(30, 100), 1'b1, dc, la);
            repeat ($urandom_range(2)) begin drive_edge(); settle(); end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
